// File: rtl/sccb_config_sequencer_pkg.sv
// Shared types for the SCCB configuration sequencer: ROM entry kinds,
// FSM state encoding and entry/retry helpers.
package sccb_config_sequencer_pkg;

  typedef enum logic [1:0] {
    KIND_WRITE = 2'd0,
    KIND_DELAY = 2'd1,
    KIND_END   = 2'd2
  } entry_kind_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_ISSUE,
    ST_WAIT_DONE,
    ST_DELAY,
    ST_DONE,
    ST_ERROR
  } state_e;

  // A sub-address of all ones marks a control entry; all-ones data on top of
  // that marks the end of the table, anything else is a delay in ms.
  function automatic entry_kind_e classify_entry(input logic sub_is_marker,
                                                 input logic data_is_marker);
    if (sub_is_marker && data_is_marker) return KIND_END;
    if (sub_is_marker) return KIND_DELAY;
    return KIND_WRITE;
  endfunction

  // Width of a counter able to hold 0..max_retry.
  function automatic int unsigned retry_width(input int unsigned max_retry);
    return (max_retry > 0) ? $clog2(max_retry + 1) : 1;
  endfunction

endpackage

// File: rtl/sccb_config_sequencer_if.sv
// Write-request handshake between the configuration sequencer (master)
// and the SCCB bus master (slave).
interface sccb_config_sequencer_if #(
  parameter int unsigned REG_W  = 8,
  parameter int unsigned DATA_W = 8
);
  logic              sccb_ready;
  logic              sccb_start;
  logic [REG_W-1:0]  sccb_sub_addr;
  logic [DATA_W-1:0] sccb_data;
  logic              sccb_done;
  logic              sccb_ack_ok;

  modport master (
    input  sccb_ready, sccb_done, sccb_ack_ok,
    output sccb_start, sccb_sub_addr, sccb_data
  );

  modport slave (
    output sccb_ready, sccb_done, sccb_ack_ok,
    input  sccb_start, sccb_sub_addr, sccb_data
  );
endinterface

// File: rtl/sccb_config_sequencer_ms_delay_timer.sv
// Millisecond delay timer: loads a ms count, runs a TICKS_PER_MS prescaler
// and flags the final cycle of the delay so the caller leaves on time.
module sccb_config_sequencer_ms_delay_timer #(
  parameter int unsigned TICKS_PER_MS = 25000,
  parameter int unsigned MS_W         = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load_i,
  input  logic [MS_W-1:0] ms_i,
  input  logic            clear_i,
  output logic            expired_o
);

  localparam int unsigned TICK_W = (TICKS_PER_MS > 1) ? $clog2(TICKS_PER_MS) : 1;
  localparam logic [TICK_W-1:0] TICK_RELOAD = TICK_W'(TICKS_PER_MS - 1);
  localparam logic [MS_W-1:0]   MS_ONE      = MS_W'(1);

  logic              active_q;
  logic [TICK_W-1:0] tick_q;
  logic [MS_W-1:0]   ms_q;

  // Prescaler and ms countdown; load has priority over clear so the caller
  // can load while still outside its delay state.
  always_ff @(posedge clk) begin
    if (reset) begin
      active_q <= 1'b0;
      tick_q   <= '0;
      ms_q     <= '0;
    end else if (load_i && (ms_i != '0)) begin
      active_q <= 1'b1;
      tick_q   <= TICK_RELOAD;
      ms_q     <= ms_i;
    end else if (clear_i) begin
      active_q <= 1'b0;
      tick_q   <= '0;
      ms_q     <= '0;
    end else if (active_q) begin
      if (tick_q == '0) begin
        tick_q <= TICK_RELOAD;
        if (ms_q == MS_ONE) active_q <= 1'b0;
        else                ms_q     <= ms_q - MS_ONE;
      end else begin
        tick_q <= tick_q - TICK_W'(1);
      end
    end
  end

  // High during the last cycle of ms_i*TICKS_PER_MS.
  assign expired_o = active_q && (tick_q == '0) && (ms_q == MS_ONE);

endmodule

// File: rtl/sccb_config_sequencer.sv
// Camera configuration sequencer: walks a {sub_address, data} ROM, issues
// each write to the SCCB master with bounded NACK retry, honours per-entry
// millisecond delays and abort, and reports completion, errors and progress.
module sccb_config_sequencer
  import sccb_config_sequencer_pkg::*;
#(
  parameter int unsigned CLK_FREQ     = 25000000,
  parameter int unsigned TICKS_PER_MS = CLK_FREQ / 1000,
  parameter int unsigned ROM_AW       = 8,
  parameter int unsigned REG_W        = 8,
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned MAX_RETRY    = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    abort,
  output logic [ROM_AW-1:0]       rom_addr,
  input  logic [REG_W+DATA_W-1:0] rom_data,
  sccb_config_sequencer_if.master sccb,
  output logic                    busy,
  output logic                    done,
  output logic                    error,
  output logic [ROM_AW-1:0]       err_index,
  output logic [ROM_AW:0]         entries_written
);

  localparam int unsigned RETRY_W = retry_width(MAX_RETRY);
  localparam logic [REG_W-1:0]   SUB_MARKER  = '1;
  localparam logic [DATA_W-1:0]  DATA_MARKER = '1;
  localparam logic [RETRY_W-1:0] RETRY_MAX   = RETRY_W'(MAX_RETRY);
  localparam logic [ROM_AW:0]    ENT_ONE     = (ROM_AW + 1)'(1);
  localparam logic [ROM_AW-1:0]  ADDR_ONE    = ROM_AW'(1);

  state_e              state_q;
  logic [ROM_AW-1:0]   rom_addr_q;
  logic [REG_W-1:0]    sub_q;
  logic [DATA_W-1:0]   data_q;
  logic                sccb_start_q;
  logic                busy_q;
  logic                done_q;
  logic                error_q;
  logic [ROM_AW-1:0]   err_index_q;
  logic [ROM_AW:0]     entries_q;
  logic [RETRY_W-1:0]  retry_q;
  logic                abort_pend_q;

  logic [REG_W-1:0]    ent_sub;
  logic [DATA_W-1:0]   ent_dat;
  entry_kind_e         ent_kind;
  logic                last_entry;
  logic                timer_load;
  logic                timer_clear;
  logic                timer_expired;

  assign ent_sub    = rom_data[REG_W+DATA_W-1 -: REG_W];
  assign ent_dat    = rom_data[DATA_W-1:0];
  assign ent_kind   = classify_entry(ent_sub == SUB_MARKER, ent_dat == DATA_MARKER);
  assign last_entry = (rom_addr_q == '1);

  assign timer_load  = (state_q == ST_DECODE) && !abort && (ent_kind == KIND_DELAY);
  assign timer_clear = (state_q != ST_DELAY);

  sccb_config_sequencer_ms_delay_timer #(
    .TICKS_PER_MS (TICKS_PER_MS),
    .MS_W         (DATA_W)
  ) u_timer (
    .clk       (clk),
    .reset     (reset),
    .load_i    (timer_load),
    .ms_i      (ent_dat),
    .clear_i   (timer_clear),
    .expired_o (timer_expired)
  );

  // Sequencer FSM with registered outputs. Advancing past the last ROM
  // index without an END entry finishes the run instead of wrapping.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      rom_addr_q   <= '0;
      sub_q        <= '0;
      data_q       <= '0;
      sccb_start_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      err_index_q  <= '0;
      entries_q    <= '0;
      retry_q      <= '0;
      abort_pend_q <= 1'b0;
    end else begin
      sccb_start_q <= 1'b0;
      unique case (state_q)
        ST_IDLE, ST_DONE, ST_ERROR: begin
          if (start && !abort) begin
            rom_addr_q   <= '0;
            entries_q    <= '0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            busy_q       <= 1'b1;
            abort_pend_q <= 1'b0;
            state_q      <= ST_FETCH;
          end
        end

        ST_FETCH: begin
          if (abort) begin
            state_q     <= ST_ERROR;
            error_q     <= 1'b1;
            busy_q      <= 1'b0;
            err_index_q <= rom_addr_q;
          end else begin
            state_q <= ST_DECODE;
          end
        end

        ST_DECODE: begin
          if (abort) begin
            state_q     <= ST_ERROR;
            error_q     <= 1'b1;
            busy_q      <= 1'b0;
            err_index_q <= rom_addr_q;
          end else begin
            unique case (ent_kind)
              KIND_END: begin
                state_q <= ST_DONE;
                done_q  <= 1'b1;
                busy_q  <= 1'b0;
              end
              KIND_DELAY: begin
                if (ent_dat != '0) begin
                  state_q <= ST_DELAY;
                end else if (last_entry) begin
                  state_q <= ST_DONE;
                  done_q  <= 1'b1;
                  busy_q  <= 1'b0;
                end else begin
                  rom_addr_q <= rom_addr_q + ADDR_ONE;
                  state_q    <= ST_FETCH;
                end
              end
              default: begin
                sub_q   <= ent_sub;
                data_q  <= ent_dat;
                retry_q <= '0;
                state_q <= ST_ISSUE;
              end
            endcase
          end
        end

        ST_ISSUE: begin
          if (abort) begin
            state_q     <= ST_ERROR;
            error_q     <= 1'b1;
            busy_q      <= 1'b0;
            err_index_q <= rom_addr_q;
          end else if (sccb.sccb_ready) begin
            sccb_start_q <= 1'b1;
            state_q      <= ST_WAIT_DONE;
          end
        end

        ST_WAIT_DONE: begin
          // An abort here is only remembered; the transfer in flight must
          // complete before the sequencer lets go of the SCCB master.
          if (abort) abort_pend_q <= 1'b1;
          if (sccb.sccb_done) begin
            if (sccb.sccb_ack_ok) entries_q <= entries_q + ENT_ONE;
            if (abort || abort_pend_q) begin
              state_q      <= ST_ERROR;
              error_q      <= 1'b1;
              busy_q       <= 1'b0;
              err_index_q  <= rom_addr_q;
              abort_pend_q <= 1'b0;
            end else if (sccb.sccb_ack_ok) begin
              if (last_entry) begin
                state_q <= ST_DONE;
                done_q  <= 1'b1;
                busy_q  <= 1'b0;
              end else begin
                rom_addr_q <= rom_addr_q + ADDR_ONE;
                state_q    <= ST_FETCH;
              end
            end else if (retry_q < RETRY_MAX) begin
              retry_q <= retry_q + RETRY_W'(1);
              state_q <= ST_ISSUE;
            end else begin
              state_q     <= ST_ERROR;
              error_q     <= 1'b1;
              busy_q      <= 1'b0;
              err_index_q <= rom_addr_q;
            end
          end
        end

        ST_DELAY: begin
          if (abort) begin
            state_q     <= ST_ERROR;
            error_q     <= 1'b1;
            busy_q      <= 1'b0;
            err_index_q <= rom_addr_q;
          end else if (timer_expired) begin
            if (last_entry) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
            end else begin
              rom_addr_q <= rom_addr_q + ADDR_ONE;
              state_q    <= ST_FETCH;
            end
          end
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign rom_addr           = rom_addr_q;
  assign sccb.sccb_start    = sccb_start_q;
  assign sccb.sccb_sub_addr = sub_q;
  assign sccb.sccb_data     = data_q;
  assign busy               = busy_q;
  assign done               = done_q;
  assign error              = error_q;
  assign err_index          = err_index_q;
  assign entries_written    = entries_q;

endmodule
